// File: rtl/timer_irq_source_pkg.sv
// Shared definitions for the down-counting timer interrupt source:
// register offsets, CTRL bit positions, mode codes and FSM state encoding.
package timer_irq_source_pkg;

    // Word offsets on the bridge bus
    localparam logic [1:0] TMR_CTRL   = 2'd0;
    localparam logic [1:0] TMR_PRESET = 2'd1;
    localparam logic [1:0] TMR_COUNT  = 2'd2;

    // CTRL bit positions
    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    // Mode codes; 2'b1x behaves as one-shot
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } tmr_state_e;

    // Only the exact reload code reloads; every other code is one-shot.
    function automatic logic is_reload(input logic [1:0] mode);
        return (mode == MODE_RELOAD);
    endfunction

endpackage

// File: rtl/timer_irq_source_if.sv
// Bridge-side register bus of the timer.
// Bus semantics: there is no valid/ready pair. A write is accepted
// unconditionally on every rising clk edge where we=1, at word offset addr;
// rdata is a combinational read of the register selected by addr and is
// valid in the same cycle addr is presented (no wait states).
interface timer_irq_source_if;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output addr, output we, output wdata, input rdata);
    modport slave  (input addr, input we, input wdata, output rdata);
endinterface

// File: rtl/timer_irq_source.sv
// Memory-mapped down-counting timer driving one CP0 hwint line.
// Counts PRESET down to 0, then raises irq: level (held until a CTRL or
// PRESET write) in one-shot mode, a one-cycle pulse per period in reload mode.
module timer_irq_source
    import timer_irq_source_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                clr_n,
    timer_irq_source_if.slave   bus,
    output logic                irq,
    output tmr_state_e          state_dbg
);

    tmr_state_e       state_q, state_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic [WIDTH-1:0] preset_q, preset_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             flag_q, flag_d;

    logic ctrl_wr;
    logic preset_wr;
    logic reload_mode;

    assign ctrl_wr     = bus.we && (bus.addr == TMR_CTRL);
    assign preset_wr   = bus.we && (bus.addr == TMR_PRESET);
    assign reload_mode = is_reload(ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO]);

    // State and register file, cleared asynchronously by clr_n
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= S_IDLE;
            ctrl_q   <= 4'd0;
            preset_q <= '0;
            count_q  <= '0;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
        end
    end

    // Next-state logic: bus writes, counting, and interrupt flag handling
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        ctrl_d   = ctrl_wr ? bus.wdata[3:0] : ctrl_q;
        preset_d = preset_wr ? bus.wdata[WIDTH-1:0] : preset_q;
        flag_d   = flag_q;

        // A CTRL/PRESET write acknowledges the flag; reload mode self-clears it
        if (ctrl_wr || preset_wr) begin
            flag_d = 1'b0;
        end else if (flag_q && reload_mode) begin
            flag_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (ctrl_q[CTRL_EN]) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                // PRESET is sampled only here, so mid-count writes wait
                count_d = preset_q;
                state_d = S_CNT;
            end
            S_CNT: begin
                if (!ctrl_q[CTRL_EN]) begin
                    state_d = S_IDLE;
                end else if (count_q != '0) begin
                    count_d = count_q - WIDTH'(1);
                end else begin
                    state_d = S_INT;
                end
            end
            S_INT: begin
                state_d = S_IDLE;
                if (ctrl_wr) begin
                    // Bus value owns CTRL; flag survives only if new mode reloads
                    flag_d = is_reload(bus.wdata[CTRL_MODE_HI:CTRL_MODE_LO]);
                end else begin
                    flag_d = 1'b1;
                    if (!reload_mode) begin
                        ctrl_d[CTRL_EN] = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Combinational register read mux
    always_comb begin
        case (bus.addr)
            TMR_CTRL:   bus.rdata = {28'd0, ctrl_q};
            TMR_PRESET: bus.rdata = 32'(preset_q);
            TMR_COUNT:  bus.rdata = 32'(count_q);
            default:    bus.rdata = 32'd0;
        endcase
    end

    assign irq       = flag_q & ctrl_q[CTRL_IM];
    assign state_dbg = state_q;

endmodule

// File: tb/tb_timer_irq_source.sv
// Self-checking bench for timer_irq_source: a timeline model of the timer
// checked every cycle, plus directed scenarios with literal expectations.
module tb_timer_irq_source;
    import timer_irq_source_pkg::*;

    logic       clk   = 1'b0;
    logic       clr_n = 1'b1;
    logic       irq;
    tmr_state_e state_dbg;

    timer_irq_source_if bus_if();

    timer_irq_source #(.WIDTH(32)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .bus       (bus_if),
        .irq       (irq),
        .state_dbg (state_dbg)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Timeline model: a period starts when an idle timer sees EN; the edge
    // after that loads N, N edges count it to zero, the next edge decides the
    // interrupt and the one after raises the flag (m_el counts those edges).
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    logic        m_flag;
    bit          m_busy;
    longint      m_el;
    longint      m_n;

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            m_ctrl   = 4'd0;
            m_preset = 32'd0;
            m_count  = 32'd0;
            m_flag   = 1'b0;
            m_busy   = 1'b0;
            m_el     = 0;
            m_n      = 0;
        end else begin
            logic       cw;
            logic       pw;
            logic       rel;
            logic [3:0] nctrl;
            logic       nflag;
            cw    = bus_if.we && (bus_if.addr == 2'd0);
            pw    = bus_if.we && (bus_if.addr == 2'd1);
            rel   = (m_ctrl[2:1] == 2'b01);
            nctrl = cw ? bus_if.wdata[3:0] : m_ctrl;
            nflag = (cw || pw) ? 1'b0 : ((m_flag && rel) ? 1'b0 : m_flag);
            if (!m_busy) begin
                if (m_ctrl[0]) begin
                    m_busy = 1'b1;
                    m_el   = 0;
                end
            end else if (m_el == 0) begin
                m_n     = longint'(m_preset);
                m_count = m_preset;
                m_el    = 1;
            end else if (m_el <= m_n + 1) begin
                if (!m_ctrl[0]) begin
                    m_busy = 1'b0;
                end else begin
                    m_el++;
                    if (m_el <= m_n + 1) m_count = 32'(m_n - (m_el - 1));
                end
            end else begin
                m_busy = 1'b0;
                if (cw) begin
                    nflag = (bus_if.wdata[2:1] == 2'b01);
                end else begin
                    nflag = 1'b1;
                    if (!rel) nctrl[0] = 1'b0;
                end
            end
            m_ctrl = nctrl;
            m_flag = nflag;
            if (pw) m_preset = bus_if.wdata;
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (clr_n) begin
            logic [31:0] exp_rd;
            chk("irq_model", {31'd0, irq}, {31'd0, m_flag & m_ctrl[3]});
            case (bus_if.addr)
                2'd0:    exp_rd = {28'd0, m_ctrl};
                2'd1:    exp_rd = m_preset;
                2'd2:    exp_rd = m_count;
                default: exp_rd = 32'd0;
            endcase
            chk($sformatf("rdata_model@%0d", bus_if.addr), bus_if.rdata, exp_rd);
        end
    end

    // Driver tasks: inputs change 2 time units after the rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus_if.addr  = a;
        bus_if.we    = 1'b1;
        bus_if.wdata = d;
        tick();
        bus_if.we    = 1'b0;
        bus_if.addr  = 2'd2;
    endtask

    task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
        bus_if.addr = a;
        #1;
        chk(name, bus_if.rdata, exp);
        bus_if.addr = 2'd2;
    endtask

    task automatic wait_irq(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (irq) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            total++;
            bad++;
            $display("FAIL irq_timeout: irq not seen within %0d cycles", limit);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int e;
        int at;
        int at2;
        int at3;
        bus_if.addr  = 2'd0;
        bus_if.we    = 1'b0;
        bus_if.wdata = 32'd0;

        // Reset state
        #1 clr_n = 1'b0;
        #1;
        chk("reset_irq", {31'd0, irq}, 32'd0);
        rd_chk("reset_ctrl", 2'd0, 32'd0);
        @(posedge clk);
        #2 clr_n = 1'b1;
        tick();

        // Asynchronous reset in the middle of a reload count
        wr(2'd1, 32'd10);
        wr(2'd0, 32'hB);
        repeat (5) tick();
        rd_chk("count_pre_reset", 2'd2, 32'd7);
        clr_n = 1'b0;
        #1;
        chk("async_reset_irq", {31'd0, irq}, 32'd0);
        rd_chk("async_reset_ctrl", 2'd0, 32'd0);
        rd_chk("async_reset_preset", 2'd1, 32'd0);
        rd_chk("async_reset_count", 2'd2, 32'd0);
        rd_chk("async_reset_addr3", 2'd3, 32'd0);
        tick();
        rd_chk("reset_held_count", 2'd2, 32'd0);
        clr_n = 1'b1;
        tick();

        // One-shot: level irq until acknowledged
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        e = cyc;
        wait_irq(40, at);
        chk("oneshot_irq_edge", at, e + 9);
        repeat (3) tick();
        chk("oneshot_irq_held", {31'd0, irq}, 32'd1);
        rd_chk("oneshot_ctrl_en_cleared", 2'd0, 32'h8);
        wr(2'd0, 32'h8);
        chk("oneshot_ack", {31'd0, irq}, 32'd0);

        // Auto-reload: pulses every N+4 cycles
        wr(2'd0, 32'h0);
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        e = cyc;
        wait_irq(20, at);
        chk("reload_first_pulse", at, e + 7);
        tick();
        chk("reload_pulse_width", {31'd0, irq}, 32'd0);
        tick();
        rd_chk("reload_count_reloaded", 2'd2, 32'd3);
        wait_irq(20, at2);
        chk("reload_period_1", at2, at + 7);
        wait_irq(20, at3);
        chk("reload_period_2", at3, at2 + 7);
        wr(2'd0, 32'h0);
        repeat (4) tick();

        // Masking: flag pending without IM, then a CTRL write acknowledges it
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        repeat (8) tick();
        chk("masked_irq_low", {31'd0, irq}, 32'd0);
        rd_chk("masked_fsm_done", 2'd0, 32'h0);
        wr(2'd0, 32'h8);
        chk("masked_ack", {31'd0, irq}, 32'd0);

        // IM landing in the INT cycle with reload mode keeps the flag
        wr(2'd0, 32'h3);
        e = cyc;
        repeat (5) tick();
        wr(2'd0, 32'hB);
        chk("im_lands_irq", {31'd0, irq}, 32'd1);
        tick();
        chk("im_lands_pulse_end", {31'd0, irq}, 32'd0);
        wait_irq(20, at);
        chk("im_lands_next_pulse", at, e + 12);
        wr(2'd0, 32'h0);
        repeat (4) tick();

        // PRESET write mid-count, then disable
        wr(2'd1, 32'd20);
        wr(2'd0, 32'h9);
        repeat (12) tick();
        rd_chk("midcount_10", 2'd2, 32'd10);
        wr(2'd1, 32'd4);
        rd_chk("midcount_9", 2'd2, 32'd9);
        tick();
        rd_chk("midcount_8", 2'd2, 32'd8);
        tick();
        rd_chk("midcount_7", 2'd2, 32'd7);
        wr(2'd0, 32'h8);
        repeat (3) tick();
        rd_chk("disable_hold_6", 2'd2, 32'd6);
        chk("disable_no_irq", {31'd0, irq}, 32'd0);
        chk("disable_idle", {30'd0, state_dbg}, {30'd0, S_IDLE});

        // Edge values
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        e = cyc;
        wait_irq(20, at);
        chk("preset0_irq_edge", at, e + 4);
        wr(2'd0, 32'h0);
        wr(2'd1, 32'hFFFF_FFFF);
        wr(2'd0, 32'h1);
        repeat (5) tick();
        rd_chk("max_preset_count", 2'd2, 32'hFFFF_FFFC);
        wr(2'd2, 32'h55);
        wr(2'd3, 32'h1234);
        rd_chk("ro_write_count", 2'd2, 32'hFFFF_FFFA);
        rd_chk("addr3_reads_0", 2'd3, 32'd0);
        rd_chk("ro_write_preset", 2'd1, 32'hFFFF_FFFF);
        rd_chk("ro_write_ctrl", 2'd0, 32'h1);
        wr(2'd0, 32'h0);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
